// File: rtl/acorn128_dec_core.sv
`default_nettype none
// ============================================================================
// Module  : acorn128_dec_core
// Purpose : ACORN-128 bit-serial decryption datapath. Each accepted
//           ciphertext bit advances the 293-bit state by one step and yields
//           one plaintext bit.
//           Default build: every plaintext bit is emitted as its own output
//           word (m_data[0]).
//           Build option ACORN_DEC_BYTE_EN: eight plaintext bits are packed
//           LSB-first into each output byte.
// Ports   : clk, rst_n         - clock, asynchronous active-low reset
//           load, state_in     - load a fresh 293-bit cipher state
//           ca_in, cb_in       - ACORN control bits for the current step
//           c_valid/c_ready/c_bit - ciphertext bit stream
//           m_valid/m_ready/m_data - plaintext stream
//           state_out          - current internal state
//           bit_cnt            - ciphertext bits accepted since last load
// Revision: 1.0 - initial release
// ============================================================================
module acorn128_dec_core #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [292:0]     state_in,
    input  logic             ca_in,
    input  logic             cb_in,
    input  logic             c_valid,
    output logic             c_ready,
    input  logic             c_bit,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic [292:0]     state_out,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [292:0]     r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_m_valid;
    logic [7:0]       r_m_data;
`ifdef ACORN_DEC_BYTE_EN
    // Bits 0..6 of the byte being assembled; bit 7 goes straight to m_data.
    logic [6:0]       r_acc;
    logic [2:0]       r_acc_cnt;
`endif

    logic             w_accept;
    logic [292:0]     w_t;
    logic             w_ks;
    logic             w_m;
    logic             w_f;
    logic [292:0]     w_next;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // The output register may be refilled in the same cycle it is drained,
    // so a stalled consumer is the only thing that blocks the input.
    assign c_ready  = ~load & (~r_m_valid | m_ready);
    assign w_accept = c_valid & c_ready;

    // LFSR feedback taps folded into the six register boundaries.
    always_comb begin
        w_t      = r_state;
        w_t[289] = r_state[289] ^ r_state[235] ^ r_state[230];
        w_t[230] = r_state[230] ^ r_state[196] ^ r_state[193];
        w_t[193] = r_state[193] ^ r_state[160] ^ r_state[154];
        w_t[154] = r_state[154] ^ r_state[111] ^ r_state[107];
        w_t[107] = r_state[107] ^ r_state[66]  ^ r_state[61];
        w_t[61]  = r_state[61]  ^ r_state[23]  ^ r_state[0];
    end

    assign w_ks   = w_t[12] ^ w_t[154] ^ maj(w_t[235], w_t[61], w_t[193])
                  ^ ch(w_t[230], w_t[111], w_t[66]);
    assign w_m    = c_bit ^ w_ks;
    assign w_f    = w_t[0] ^ ~w_t[107] ^ maj(w_t[244], w_t[23], w_t[160])
                  ^ (ca_in & w_t[196]) ^ (cb_in & w_ks);
    // Decryption feeds the recovered plaintext back, matching the encryptor.
    assign w_next = {w_f ^ w_m, w_t[292:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= '0;
            r_bit_cnt <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
`ifdef ACORN_DEC_BYTE_EN
            r_acc     <= '0;
            r_acc_cnt <= '0;
`endif
        end else if (load) begin
            // Load outranks any accept; c_ready is low so c_bit is ignored.
            r_state   <= state_in;
            r_bit_cnt <= '0;
            r_m_valid <= 1'b0;
`ifdef ACORN_DEC_BYTE_EN
            r_acc     <= '0;
            r_acc_cnt <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_state   <= w_next;
                r_bit_cnt <= r_bit_cnt + C_CNT_ONE;
            end
`ifdef ACORN_DEC_BYTE_EN
            if (w_accept && (r_acc_cnt == 3'd7)) begin
                r_m_valid <= 1'b1;
                r_m_data  <= {w_m, r_acc};
                r_acc     <= '0;
                r_acc_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_acc[r_acc_cnt] <= w_m;
                    r_acc_cnt        <= r_acc_cnt + 3'd1;
                end
                if (m_ready) begin
                    r_m_valid <= 1'b0;
                end
            end
`else
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= {7'b0, w_m};
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
`endif
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign state_out = r_state;
    assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_acorn128_dec_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_acorn128_dec_core
// Purpose : Self-checking bench for acorn128_dec_core (both ACORN_DEC_BYTE_EN
//           builds). Single-step vector table, back-pressure stall, load and
//           reset corner cases, and a 64-bit encrypt/decrypt round trip with
//           a plaintext scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_acorn128_dec_core;

    localparam int CNT_W = 6;  // narrow so 64 accepts wrap the counter to 0
`ifdef ACORN_DEC_BYTE_EN
    localparam int BITS_PER_OUT = 8;
`else
    localparam int BITS_PER_OUT = 1;
`endif

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             load     = 1'b0;
    logic [292:0]     state_in = '0;
    logic             ca_in    = 1'b0;
    logic             cb_in    = 1'b0;
    logic             c_valid  = 1'b0;
    logic             c_bit    = 1'b0;
    logic             m_ready  = 1'b0;
    logic             c_ready;
    logic             m_valid;
    logic [7:0]       m_data;
    logic [292:0]     state_out;
    logic [CNT_W-1:0] bit_cnt;

    acorn128_dec_core #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .state_in  (state_in),
        .ca_in     (ca_in),
        .cb_in     (cb_in),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .c_bit     (c_bit),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .state_out (state_out),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [292:0] act, input logic [292:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic f_maj(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    function automatic logic f_ch(input logic x, input logic y, input logic z);
        return x ? y : z;
    endfunction

    function automatic logic [292:0] mk_t(input logic [292:0] s);
        logic [292:0] t;
        t = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        return t;
    endfunction

    function automatic logic mdl_ks(input logic [292:0] s);
        logic [292:0] t;
        t = mk_t(s);
        return t[12] ^ t[154] ^ f_maj(t[235], t[61], t[193]) ^ f_ch(t[230], t[111], t[66]);
    endfunction

    // One decryption step: returns next state, m = recovered plaintext bit.
    function automatic logic [292:0] mdl_step(input logic [292:0] s, input logic ca,
                                              input logic cb, input logic cbit,
                                              output logic m);
        logic [292:0] t;
        logic         ks;
        logic         f;
        t  = mk_t(s);
        ks = mdl_ks(s);
        m  = cbit ^ ks;
        f  = t[0] ^ ~t[107] ^ f_maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
        return {f ^ m, t[292:1]};
    endfunction

    function automatic logic [292:0] rand_state();
        logic [319:0] r;
        for (int w = 0; w < 10; w++) r[w*32 +: 32] = $urandom;
        return r[292:0];
    endfunction

    function automatic logic [292:0] bit_at(input int i);
        logic [292:0] one;
        one = 293'd1;
        return one << i;
    endfunction

    // ---------------- plaintext scoreboard ----------------
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;
    bit         sb_on = 1'b0;

    always @(negedge clk) begin
        if (sb_on && rst_n && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got %h expected no output", m_data);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_plain", m_data, sb_exp);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        logic [292:0] st;
        logic         ca;
        logic         cb;
        logic         c;
        logic         m;
        logic [292:0] exp_st;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [292:0] k;
        logic [292:0] s;
        logic [7:0]   eb;
        logic         m;
        logic         acc;
        logic         p;
        int           nb;
        int           wait_n;

        vt[0] = '{"zero_c1",  '0,          1'b0, 1'b0, 1'b1, 1'b1, '0};
        vt[1] = '{"zero_c0",  '0,          1'b0, 1'b0, 1'b0, 1'b0, bit_at(292)};
        vt[2] = '{"s12_c1",   bit_at(12),  1'b0, 1'b0, 1'b1, 1'b0, bit_at(292) | bit_at(11)};
        vt[3] = '{"s12_cb",   bit_at(12),  1'b0, 1'b1, 1'b0, 1'b1, bit_at(292) | bit_at(11)};
        vt[4] = '{"s0_cacb",  bit_at(0),   1'b1, 1'b1, 1'b1, 1'b1, bit_at(292) | bit_at(60)};
        vt[5] = '{"s196_ca",  bit_at(196), 1'b1, 1'b0, 1'b0, 1'b0, bit_at(229) | bit_at(195)};

        // ---- reset state ----
        #12;
        check("rst_state", state_out, '0);
        check("rst_cnt", bit_cnt, '0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        tick();
        rst_n = 1'b1;

        // ---- single-step table ----
        for (int i = 0; i < 6; i++) begin
            tick();
            load = 1'b1; state_in = vt[i].st; c_valid = 1'b0;
            tick();
            load = 1'b0;
            check({vt[i].name, "_load_cnt"}, bit_cnt, '0);
            check({vt[i].name, "_load_mv"}, m_valid, 0);
            ca_in = vt[i].ca; cb_in = vt[i].cb; c_bit = vt[i].c; c_valid = 1'b1;
            tick();
            c_valid = 1'b0;
            check({vt[i].name, "_state"}, state_out, vt[i].exp_st);
            check({vt[i].name, "_cnt"}, bit_cnt, 1);
`ifdef ACORN_DEC_BYTE_EN
            check({vt[i].name, "_mv"}, m_valid, 0);
`else
            check({vt[i].name, "_mv"}, m_valid, 1);
            check({vt[i].name, "_mdata"}, m_data, {7'b0, vt[i].m});
`endif
        end

        // ---- back-pressure stall ----
        k = rand_state();
        load = 1'b1; state_in = k; m_ready = 1'b0; ca_in = 1'b0; cb_in = 1'b0; c_bit = 1'b1;
        tick();
        load = 1'b0; c_valid = 1'b1;
        s = k; eb = '0;
        for (int i = 0; i < BITS_PER_OUT; i++) begin
            s = mdl_step(s, 1'b0, 1'b0, 1'b1, m);
            eb[i] = m;
        end
        wait_n = 0;
        while (!m_valid && wait_n < 20) begin
            tick();
            wait_n++;
        end
        if (!m_valid) begin
            checks++; errors++;
            $display("FAIL stall_timeout: got m_valid=0 expected 1 within 20 cycles");
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            check("stall_cready", c_ready, 0);
            check("stall_mv", m_valid, 1);
            check("stall_mdata", m_data, eb);
            check("stall_state", state_out, s);
            check("stall_cnt", bit_cnt, BITS_PER_OUT);
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        c_valid = 1'b0;
        for (int i = 0; i < 4; i++) s = mdl_step(s, 1'b0, 1'b0, 1'b1, m);
        check("resume_cnt", bit_cnt, BITS_PER_OUT + 4);
        check("resume_state", state_out, s);
`ifdef ACORN_DEC_BYTE_EN
        check("resume_mv", m_valid, 0);
`else
        check("resume_mv", m_valid, 1);
        check("resume_mdata", m_data, {7'b0, m});
`endif

        // ---- asynchronous reset mid-stream ----
        c_valid = 1'b1;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state_out, '0);
        check("arst_cnt", bit_cnt, '0);
        check("arst_mv", m_valid, 0);
        check("arst_mdata", m_data, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();  // accepts from the zero state leave a partial byte

        // ---- load colliding with an accept ----
        k = rand_state();
        load = 1'b1; state_in = k; c_valid = 1'b1; c_bit = 1'b0;
        #1;
        check("load_cready", c_ready, 0);
        tick();
        load = 1'b0; c_valid = 1'b0;
        check("loadwin_cnt", bit_cnt, '0);
        check("loadwin_mv", m_valid, 0);
        check("loadwin_state", state_out, k);

        // ---- 64-bit encrypt/decrypt round trip ----
        sb_on = 1'b1;
        s = k; eb = '0; nb = 0;
        for (int i = 0; i < 64; i++) begin
            p     = 1'($urandom);
            ca_in = 1'($urandom);
            cb_in = 1'($urandom);
            c_bit = p ^ mdl_ks(s);          // encryptor output
            s     = mdl_step(s, ca_in, cb_in, c_bit, m);
`ifdef ACORN_DEC_BYTE_EN
            eb[nb] = p;
            nb++;
            if (nb == 8) begin
                sb_q.push_back(eb);
                eb = '0;
                nb = 0;
            end
`else
            sb_q.push_back({7'b0, p});
`endif
            c_valid = 1'b1;
            wait_n = 0;
            acc = 1'b0;
            while (!acc && wait_n < 50) begin
                @(negedge clk);
                acc = c_ready;
                @(posedge clk);
                #1;
                m_ready = ($urandom_range(3) != 0);
                wait_n++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL rt_timeout: got no accept expected accept of bit %0d", i);
            end
        end
        c_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        sb_on = 1'b0;
        check("rt_sb_empty", sb_q.size(), 0);
        check("rt_state", state_out, s);
        check("rt_cnt_wrap", bit_cnt, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
